dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port 24-bit data memory between two requesters: port 0 = CPU
//  load/store, port 1 = host/loader (program data preload, debug readback).
//  Round-robin arbitration, valid/ready request handshake, and a bounded burst lock
//  for port 1. Sits between the CPU execute stage, the host interface and the memory macro.
// PARAMETERS
//  DATA_W     24  data word width
//  ADDR_W     8   memory address width (depth = 2**ADDR_W)
//  MAX_BURST  16  maximum consecutive grants port 1 may hold under lock (>=1)
// PORTS
//  clk           in   1       clock, all logic on posedge
//  rst_n         in   1       synchronous active-low reset
//  p0_valid      in   1       CPU request valid
//  p0_ready      out  1       CPU request accepted this cycle
//  p0_we         in   1       1 = store, 0 = load
//  p0_addr       in   ADDR_W  CPU address
//  p0_wdata      in   DATA_W  CPU store data
//  p0_rvalid     out  1       CPU response (load data or store ack)
//  p0_rdata      out  DATA_W  CPU load data (0 on store ack)
//  p1_valid/p1_ready/p1_we/p1_addr/p1_wdata/p1_rvalid/p1_rdata: as port 0, host side
//  p1_lock       in   1       host requests consecutive grants (burst)
//  mem_en        out  1       memory access strobe
//  mem_we        out  1       memory write enable
//  mem_addr      out  ADDR_W  memory address
//  mem_wdata     out  DATA_W  memory write data
//  mem_rdata     in   DATA_W  memory read data, valid 1 cycle after mem_en&&!mem_we
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): rr_last<=1 (port 0 wins first tie), lock_state<=UNLOCKED,
//    burst_cnt<=0, resp_pending<=0; p*_rvalid=0, p*_rdata=0. Combinational outputs
//    p*_ready, mem_en, mem_we forced 0 while rst_n=0.
//  - Grant (combinational, one per cycle): only one valid -> that port; both valid ->
//    port != rr_last, unless lock_state=LOCKED -> port 1. Granted port: ready=1,
//    mem_en=1, mem_we/addr/wdata = that port's signals. No valid -> mem_en=0, grants nothing.
//  - Requester holds valid/we/addr/wdata stable until ready; dropping valid early is legal.
//  - rr_last updates to granted port on every accepted request.
//  - Response: exactly 1 cycle after acceptance, granted port's rvalid=1 for one cycle;
//    load -> rdata=mem_rdata; store -> rdata=0. Throughput 1 access/cycle, back-to-back ok.
//  - Read-after-write to same address in consecutive cycles returns new data (memory
//    write-first contract); arbiter adds no forwarding.
//  - Lock FSM: UNLOCKED -> LOCKED when port 1 accepted with p1_lock=1 (burst_cnt<=1).
//    LOCKED: each port-1 accept increments burst_cnt; -> UNLOCKED when p1_lock=0,
//    p1_valid=0, or burst_cnt reaches MAX_BURST on an accept (then rr_last=1 so port 0
//    wins next tie). burst_cnt cleared on entering UNLOCKED. Port 0 never starved
//    longer than MAX_BURST cycles.
//  - Reset mid-access: pending response discarded (rvalid=0 next cycle); memory write
//    already strobed is not undone.
//  - Address wrap: ADDR_W bits only; callers truncate wider CPU register values.
// STRUCTURE
//  - Shared package elvm_pkg: DATA_W/ADDR_W constants, lock_state_t enum
//    {UNLOCKED, LOCKED}, port index constants PORT_CPU=0, PORT_HOST=1.
//  - One sub-module natural: rr_grant2 (2-way round-robin grant from valids, rr_last,
//    force_p1). Response steering (registered grant id + we) stays in top.
// TESTING
//  1 Reset: rst_n=0 2 cycles with both valid -> ready=0, mem_en=0, rvalid=0 throughout.
//  2 p0 store addr 8'h05 data 24'h000041, next p0 load 8'h05 -> p0_rvalid 1 cycle later,
//    p0_rdata=24'h000041; p1_rvalid stays 0.
//  3 Both valid continuously, p1_lock=0 -> grants alternate 0,1,0,1; each rvalid on
//    correct port one cycle after its ready.
//  4 MAX_BURST=4, p1_lock=1, both valid -> p1 granted 4 consecutive cycles, then p0,
//    then p1 resumes LOCKED burst.
//  5 p1 lock burst of 2 then p1_lock=0 with p0 valid -> p0 granted next cycle, burst_cnt=0.
//  6 Assert rst_n=0 in cycle after p1 load accept -> p1_rvalid never asserted; after
//    release, p0 and p1 simultaneous -> p0 granted first.

Source files
------------

// File: rtl/elvm_pkg.sv
// Shared constants and types for the data-memory arbiter: word/address widths,
// the host burst-lock state and the requester port indices.
package elvm_pkg;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 8;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_grant2.sv
// Two-way round-robin grant: the port that did not win last gets a tie,
// and force_p1 hands every tie to the host while its burst lock is held.
module rr_grant2 (
    input  logic valid0,
    input  logic valid1,
    input  logic rr_last,
    input  logic force_p1,
    output logic gnt0,
    output logic gnt1
);
    import elvm_pkg::*;

    // Grant decision from the current valids and arbitration history
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (valid0 && valid1) begin
            if (force_p1) begin
                gnt1 = 1'b1;
            end else if (rr_last == PORT_HOST) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else if (valid0) begin
            gnt0 = 1'b1;
        end else if (valid1) begin
            gnt1 = 1'b1;
        end else begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and the host
// (port 1) with round-robin arbitration and a bounded host burst lock.
module dmem_arbiter #(
    parameter int DATA_W    = elvm_pkg::DATA_W,
    parameter int ADDR_W    = elvm_pkg::ADDR_W,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              p1_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import elvm_pkg::*;

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic              gnt0_s;
    logic              gnt1_s;
    logic              force_p1_s;
    logic              rr_last_r;
    logic              rr_last_s;
    lock_state_t       lock_state_r;
    lock_state_t       lock_state_s;
    logic [CNT_W-1:0]  burst_cnt_r;
    logic [CNT_W-1:0]  burst_cnt_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              rsp0_r;
    logic              rsp1_r;
    logic              rsp_we_r;

    assign force_p1_s = (lock_state_r == LOCKED);
    assign cnt_inc_s  = burst_cnt_r + CNT_W'(1'b1);

    rr_grant2 u_grant (
        .valid0   (p0_valid),
        .valid1   (p1_valid),
        .rr_last  (rr_last_r),
        .force_p1 (force_p1_s),
        .gnt0     (gnt0_s),
        .gnt1     (gnt1_s)
    );

    // Handshake and memory request steering; all strobes held off during reset
    always_comb begin
        p0_ready  = gnt0_s && rst_n;
        p1_ready  = gnt1_s && rst_n;
        mem_en    = (gnt0_s || gnt1_s) && rst_n;
        if (gnt1_s) begin
            mem_we    = p1_we && rst_n;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end else if (gnt0_s) begin
            mem_we    = p0_we && rst_n;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end
    end

    // Round-robin history, lock state and burst counter next-state
    always_comb begin
        rr_last_s    = rr_last_r;
        lock_state_s = lock_state_r;
        burst_cnt_s  = burst_cnt_r;
        if (p0_ready) begin
            rr_last_s = PORT_CPU;
        end else if (p1_ready) begin
            rr_last_s = PORT_HOST;
        end else begin
            rr_last_s = rr_last_r;
        end
        case (lock_state_r)
            UNLOCKED: begin
                // A single-grant burst limit never actually enters the lock
                if (p1_ready && p1_lock && (CNT_W'(MAX_BURST) != CNT_W'(1'b1))) begin
                    lock_state_s = LOCKED;
                    burst_cnt_s  = CNT_W'(1'b1);
                end else begin
                    lock_state_s = UNLOCKED;
                    burst_cnt_s  = {CNT_W{1'b0}};
                end
            end
            LOCKED: begin
                if (!p1_valid || !p1_lock) begin
                    lock_state_s = UNLOCKED;
                    burst_cnt_s  = {CNT_W{1'b0}};
                end else if (p1_ready && (cnt_inc_s == CNT_W'(MAX_BURST))) begin
                    lock_state_s = UNLOCKED;
                    burst_cnt_s  = {CNT_W{1'b0}};
                    rr_last_s    = PORT_HOST;
                end else if (p1_ready) begin
                    burst_cnt_s  = cnt_inc_s;
                end else begin
                    burst_cnt_s  = burst_cnt_r;
                end
            end
            default: begin
                lock_state_s = UNLOCKED;
                burst_cnt_s  = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and response-steering registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last_r    <= PORT_HOST;
            lock_state_r <= UNLOCKED;
            burst_cnt_r  <= {CNT_W{1'b0}};
            rsp0_r       <= 1'b0;
            rsp1_r       <= 1'b0;
            rsp_we_r     <= 1'b0;
        end else begin
            rr_last_r    <= rr_last_s;
            lock_state_r <= lock_state_s;
            burst_cnt_r  <= burst_cnt_s;
            rsp0_r       <= p0_ready;
            rsp1_r       <= p1_ready;
            rsp_we_r     <= mem_we;
        end
    end

    // Masking with rst_n drops a response whose reset arrives in its own cycle
    always_comb begin
        p0_rvalid = rsp0_r && rst_n;
        p1_rvalid = rsp1_r && rst_n;
        if (p0_rvalid && !rsp_we_r) begin
            p0_rdata = mem_rdata;
        end else begin
            p0_rdata = {DATA_W{1'b0}};
        end
        if (p1_rvalid && !rsp_we_r) begin
            p1_rdata = mem_rdata;
        end else begin
            p1_rdata = {DATA_W{1'b0}};
        end
    end

endmodule
